// File: rtl/dmem_ahb_master.sv
// dmem_ahb_master: AHB-Lite master for the core data-memory port.
// Turns one load/store request into a non-pipelined AHB address + data phase.
//
// Ports:
//   ms_riscv32_mp_clk_in / _rst_in : clock, synchronous active-high reset
//   ms_riscv32_mp_dmaddr_in        : word address (bits [1:0] ignored)
//   ms_riscv32_mp_dmdata_in        : lane-aligned store data
//   ms_riscv32_mp_dmwr_mask_in     : byte write mask
//   ms_riscv32_mp_dmwr_req_in      : store request
//   ms_riscv32_mp_dmrd_req_in      : load request (always a word)
//   ms_riscv32_mp_dmdata_out       : load data, held until the next load
//   rd_valid_out                   : 1-cycle pulse, load data valid
//   stall_out                      : core holds request and pipeline
//   err_out                        : 1-cycle pulse on any failed request
//   ahb_*                          : AHB-Lite master signals
module dmem_ahb_master #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    input  logic [31:0] ms_riscv32_mp_dmaddr_in,
    input  logic [31:0] ms_riscv32_mp_dmdata_in,
    input  logic [3:0]  ms_riscv32_mp_dmwr_mask_in,
    input  logic        ms_riscv32_mp_dmwr_req_in,
    input  logic        ms_riscv32_mp_dmrd_req_in,
    output logic [31:0] ms_riscv32_mp_dmdata_out,
    output logic        rd_valid_out,
    output logic        stall_out,
    output logic        err_out,
    output logic [31:0] ahb_haddr_out,
    output logic        ahb_hwrite_out,
    output logic [2:0]  ahb_hsize_out,
    output logic [1:0]  ahb_htrans_out,
    output logic [31:0] ahb_hwdata_out,
    input  logic [31:0] ahb_hrdata_in,
    input  logic        ahb_hready_in,
    input  logic        ahb_hresp_in
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, ERR} state_t;

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] tcnt;
    logic [31:0]   wdata;

    logic       mask_ok;
    logic [2:0] msize;
    logic [1:0] moff;
    logic       wr;
    logic       rd;
    logic       req_bad;
    logic       req_ok;
    logic       busy;
    logic       tmo;
    logic       accept;
    logic       to_data;
    logic       done;
    logic       fin;
    logic       err_set;

    assign wr = ms_riscv32_mp_dmwr_req_in;
    assign rd = ms_riscv32_mp_dmrd_req_in;

    always_comb begin
        mask_ok = 1'b1;
        msize   = 3'b000;
        moff    = 2'b00;
        case (ms_riscv32_mp_dmwr_mask_in)
            4'b0001: moff = 2'b00;
            4'b0010: moff = 2'b01;
            4'b0100: moff = 2'b10;
            4'b1000: moff = 2'b11;
            4'b0011: msize = 3'b001;
            4'b1100: begin
                msize = 3'b001;
                moff  = 2'b10;
            end
            4'b1111: msize = 3'b010;
            default: mask_ok = 1'b0;
        endcase
    end

    assign req_bad = (wr & rd) | (wr & ~mask_ok);
    assign req_ok  = (wr | rd) & ~req_bad;
    assign busy    = (state == ADDR) | (state == DATA);
    // Fires on the TIMEOUT_CYCLES-th consecutive wait cycle.
    assign tmo     = busy & ~ahb_hready_in & (tcnt == TMO_LAST);

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) state <= IDLE;
        else                      state <= state_n;
    end

    // fin marks every cycle that ends a transfer (done, error, timeout),
    // so the core is released exactly once whatever the outcome.
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        to_data = 1'b0;
        done    = 1'b0;
        fin     = 1'b0;
        err_set = 1'b0;
        case (state)
            IDLE: begin
                if (req_ok) begin
                    accept  = 1'b1;
                    state_n = ADDR;
                end else if (req_bad) begin
                    err_set = 1'b1;
                end
            end
            ADDR: begin
                if (ahb_hready_in) begin
                    to_data = 1'b1;
                    state_n = DATA;
                end else if (tmo) begin
                    fin     = 1'b1;
                    err_set = 1'b1;
                    state_n = IDLE;
                end
            end
            DATA: begin
                if (ahb_hready_in) begin
                    fin     = 1'b1;
                    state_n = IDLE;
                    if (ahb_hresp_in) err_set = 1'b1;
                    else              done    = 1'b1;
                end else if (ahb_hresp_in) begin
                    state_n = ERR;
                end else if (tmo) begin
                    fin     = 1'b1;
                    err_set = 1'b1;
                    state_n = IDLE;
                end
            end
            ERR: begin
                if (ahb_hready_in) begin
                    fin     = 1'b1;
                    err_set = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign stall_out = ((state == IDLE) & req_ok) |
                       ((state != IDLE) & ~fin);

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            tcnt                     <= '0;
            wdata                    <= '0;
            ahb_haddr_out            <= '0;
            ahb_hwrite_out           <= 1'b0;
            ahb_hsize_out            <= 3'b000;
            ahb_htrans_out           <= 2'b00;
            ahb_hwdata_out           <= '0;
            ms_riscv32_mp_dmdata_out <= '0;
            rd_valid_out             <= 1'b0;
            err_out                  <= 1'b0;
        end else begin
            rd_valid_out <= 1'b0;
            err_out      <= err_set;
            if (state_n != state)
                tcnt <= '0;
            else if (busy && !ahb_hready_in)
                tcnt <= tcnt + CW'(1);
            if (accept) begin
                ahb_htrans_out <= 2'b10;
                ahb_hwrite_out <= wr;
                wdata          <= ms_riscv32_mp_dmdata_in;
                if (wr) begin
                    ahb_haddr_out <= {ms_riscv32_mp_dmaddr_in[31:2], moff};
                    ahb_hsize_out <= msize;
                end else begin
                    ahb_haddr_out <= {ms_riscv32_mp_dmaddr_in[31:2], 2'b00};
                    ahb_hsize_out <= 3'b010;
                end
            end
            if (to_data) begin
                ahb_htrans_out <= 2'b00;
                ahb_hwdata_out <= wdata;
            end
            if (fin) ahb_htrans_out <= 2'b00;
            if (done && !ahb_hwrite_out) begin
                ms_riscv32_mp_dmdata_out <= ahb_hrdata_in;
                rd_valid_out             <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_ahb_master.sv
// tb_dmem_ahb_master: self-checking bench for dmem_ahb_master.
// Scenario tasks plus randomized transactions against a transaction-level model.
module tb_dmem_ahb_master;

    localparam int TMO = 16;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic        wr_req;
    logic        rd_req;
    logic [31:0] dmdata;
    logic        rdv;
    logic        stall;
    logic        err;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    int compared = 0;
    int mismatched = 0;

    logic [31:0] exp_dm;

    int          o_cycles;
    int          o_stall_hi;
    int          o_nonseq;
    logic [31:0] o_haddr;
    logic [2:0]  o_hsize;
    logic        o_hwrite;
    logic [31:0] o_hwdata;
    int          o_err_cnt;
    int          o_err_at;
    int          o_rdv_cnt;
    int          o_rdv_at;
    bit          o_hung;

    typedef struct {
        int          cycles;
        int          nonseq;
        logic [31:0] haddr;
        logic [2:0]  hsize;
        bit          bus;
        bit          dphase;
        bit          err;
        bit          rdv;
    } exp_t;

    dmem_ahb_master #(.TIMEOUT_CYCLES(TMO)) dut (
        .ms_riscv32_mp_clk_in      (clk),
        .ms_riscv32_mp_rst_in      (rst),
        .ms_riscv32_mp_dmaddr_in   (addr),
        .ms_riscv32_mp_dmdata_in   (wdata),
        .ms_riscv32_mp_dmwr_mask_in(mask),
        .ms_riscv32_mp_dmwr_req_in (wr_req),
        .ms_riscv32_mp_dmrd_req_in (rd_req),
        .ms_riscv32_mp_dmdata_out  (dmdata),
        .rd_valid_out              (rdv),
        .stall_out                 (stall),
        .err_out                   (err),
        .ahb_haddr_out             (haddr),
        .ahb_hwrite_out            (hwrite),
        .ahb_hsize_out             (hsize),
        .ahb_htrans_out            (htrans),
        .ahb_hwdata_out            (hwdata),
        .ahb_hrdata_in             (hrdata),
        .ahb_hready_in             (hready),
        .ahb_hresp_in              (hresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level expectations computed from the mask rules and
    // the wait/response plan given to the slave.
    function automatic exp_t model(bit w, bit r, logic [31:0] a,
                                   logic [3:0] m, int aw, int dw, bit berr);
        exp_t e;
        int n;
        int lo;
        bit legal;
        n  = $countones(m);
        lo = 0;
        for (int i = 3; i >= 0; i--) if (m[i]) lo = i;
        legal = (n == 1) || (n == 4) ||
                (n == 2 && (lo == 0 || lo == 2) && m[lo+1]);
        e.bus    = (w != r) && (r || legal);
        e.haddr  = (a & 32'hFFFF_FFFC) + (r ? 0 : lo);
        e.hsize  = r ? 3'd2 : (n == 4 ? 3'd2 : (n == 2 ? 3'd1 : 3'd0));
        e.rdv    = 1'b0;
        e.dphase = 1'b0;
        if (!e.bus) begin
            e.cycles = 1;
            e.nonseq = 0;
            e.err    = 1'b1;
        end else if (aw >= TMO) begin
            e.cycles = 1 + TMO;
            e.nonseq = TMO;
            e.err    = 1'b1;
        end else if (dw >= TMO) begin
            e.cycles = 2 + aw + TMO;
            e.nonseq = aw + 1;
            e.err    = 1'b1;
            e.dphase = 1'b1;
        end else if (berr) begin
            e.cycles = 4 + aw + dw;
            e.nonseq = aw + 1;
            e.err    = 1'b1;
            e.dphase = 1'b1;
        end else begin
            e.cycles = 3 + aw + dw;
            e.nonseq = aw + 1;
            e.err    = 1'b0;
            e.rdv    = r;
            e.dphase = 1'b1;
        end
        return e;
    endfunction

    // Drives one request and plays the slave; holds the request while
    // stall is high, then watches two more cycles for the pulses.
    task automatic do_txn(input bit w, input bit r, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] m,
                          input int aw, input int dw, input bit berr,
                          input logic [31:0] rdata);
        bit dph;
        bit go_d;
        bit fin;
        bit seen;
        int aw_c;
        int dw_c;
        int estep;
        o_cycles = 0;
        o_stall_hi = 0;
        o_nonseq = 0;
        o_haddr = '0;
        o_hsize = '0;
        o_hwrite = 1'b0;
        o_hwdata = '0;
        o_err_cnt = 0;
        o_err_at = -1;
        o_rdv_cnt = 0;
        o_rdv_at = -1;
        o_hung = 1'b0;
        dph = 1'b0;
        fin = 1'b0;
        seen = 1'b0;
        aw_c = 0;
        dw_c = 0;
        estep = 0;
        wr_req = w;
        rd_req = r;
        addr = a;
        wdata = d;
        mask = m;
        hrdata = rdata;
        for (int k = 0; k < 60 && !fin; k++) begin
            go_d = 1'b0;
            hresp = 1'b0;
            if (dph) begin
                if (dw_c < dw) begin
                    hready = 1'b0;
                    dw_c++;
                end else if (berr) begin
                    hready = (estep != 0);
                    hresp = 1'b1;
                    estep++;
                end else begin
                    hready = 1'b1;
                end
            end else if (htrans == 2'b10) begin
                if (aw_c < aw) begin
                    hready = 1'b0;
                    aw_c++;
                end else begin
                    hready = 1'b1;
                end
            end else begin
                hready = 1'b1;
            end
            @(negedge clk);
            if (stall) o_stall_hi++;
            if (err) begin
                o_err_cnt++;
                if (o_err_at < 0) o_err_at = k;
            end
            if (rdv) begin
                o_rdv_cnt++;
                if (o_rdv_at < 0) o_rdv_at = k;
            end
            if (htrans == 2'b10) begin
                o_nonseq++;
                if (!seen) begin
                    o_haddr = haddr;
                    o_hsize = hsize;
                    o_hwrite = hwrite;
                end
                seen = 1'b1;
                if (hready) go_d = 1'b1;
            end
            if (dph) o_hwdata = hwdata;
            if (!stall) begin
                o_cycles = k + 1;
                fin = 1'b1;
            end
            tick();
            if (go_d) dph = 1'b1;
        end
        if (!fin) o_hung = 1'b1;
        wr_req = 1'b0;
        rd_req = 1'b0;
        hready = 1'b1;
        hresp = 1'b0;
        for (int j = 0; j < 2; j++) begin
            @(negedge clk);
            if (err) begin
                o_err_cnt++;
                if (o_err_at < 0) o_err_at = o_cycles + j;
            end
            if (rdv) begin
                o_rdv_cnt++;
                if (o_rdv_at < 0) o_rdv_at = o_cycles + j;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wr_req = 1'b0;
        rd_req = 1'b0;
        addr = '0;
        wdata = '0;
        mask = '0;
        hrdata = '0;
        hready = 1'b1;
        hresp = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        compared++;
        if ({htrans, haddr, hsize, hwrite, hwdata, dmdata, rdv, err, stall} !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs: htrans=%b haddr=%h hsize=%b hwrite=%b hwdata=%h dm=%h rdv=%b err=%b stall=%b, want all 0",
                     htrans, haddr, hsize, hwrite, hwdata, dmdata, rdv, err, stall);
        end
        tick();
        rst = 1'b0;
        tick();
        exp_dm = '0;
    endtask

    task automatic test_store_byte();
        do_txn(1'b1, 1'b0, 32'h0000_1000, 32'h00AB_0000, 4'b0100, 0, 0, 1'b0, 32'h0);
        compared++;
        if (o_haddr !== 32'h0000_1002 || o_hsize !== 3'b000 || o_hwrite !== 1'b1) begin
            mismatched++;
            $display("FAIL store_byte_addr: haddr=%h hsize=%b hwrite=%b, want 00001002/000/1",
                     o_haddr, o_hsize, o_hwrite);
        end
        compared++;
        if (o_hwdata !== 32'h00AB_0000) begin
            mismatched++;
            $display("FAIL store_byte_hwdata: got %h want 00ab0000", o_hwdata);
        end
        compared++;
        if (o_cycles !== 3 || o_stall_hi !== 2 || o_nonseq !== 1) begin
            mismatched++;
            $display("FAIL store_byte_timing: cycles=%0d stall_hi=%0d nonseq=%0d, want 3/2/1",
                     o_cycles, o_stall_hi, o_nonseq);
        end
        compared++;
        if (o_err_cnt !== 0 || o_rdv_cnt !== 0) begin
            mismatched++;
            $display("FAIL store_byte_pulses: err=%0d rdv=%0d, want 0/0", o_err_cnt, o_rdv_cnt);
        end
    endtask

    task automatic test_load_wait();
        do_txn(1'b0, 1'b1, 32'h0000_2004, 32'h0, 4'b0000, 0, 3, 1'b0, 32'hDEAD_BEEF);
        exp_dm = 32'hDEAD_BEEF;
        compared++;
        if (o_haddr !== 32'h0000_2004 || o_hsize !== 3'b010 || o_hwrite !== 1'b0) begin
            mismatched++;
            $display("FAIL load_wait_addr: haddr=%h hsize=%b hwrite=%b, want 00002004/010/0",
                     o_haddr, o_hsize, o_hwrite);
        end
        compared++;
        if (o_cycles !== 6) begin
            mismatched++;
            $display("FAIL load_wait_cycles: got %0d want 6", o_cycles);
        end
        compared++;
        if (o_rdv_cnt !== 1 || o_rdv_at !== 6 || o_err_cnt !== 0) begin
            mismatched++;
            $display("FAIL load_wait_pulses: rdv=%0d at %0d err=%0d, want 1 at 6, err 0",
                     o_rdv_cnt, o_rdv_at, o_err_cnt);
        end
        compared++;
        if (dmdata !== exp_dm) begin
            mismatched++;
            $display("FAIL load_wait_data: got %h want %h", dmdata, exp_dm);
        end
    endtask

    task automatic test_illegal();
        do_txn(1'b1, 1'b0, 32'h0000_4000, 32'h1234_5678, 4'b0110, 0, 0, 1'b0, 32'h0);
        compared++;
        if (o_err_cnt !== 1 || o_err_at !== 1 || o_nonseq !== 0 || o_stall_hi !== 0) begin
            mismatched++;
            $display("FAIL illegal_mask: err=%0d at %0d nonseq=%0d stall_hi=%0d, want 1 at 1, 0, 0",
                     o_err_cnt, o_err_at, o_nonseq, o_stall_hi);
        end
        do_txn(1'b1, 1'b1, 32'h0000_4004, 32'h1234_5678, 4'b1111, 0, 0, 1'b0, 32'h0);
        compared++;
        if (o_err_cnt !== 1 || o_err_at !== 1 || o_nonseq !== 0 || o_stall_hi !== 0) begin
            mismatched++;
            $display("FAIL conflict: err=%0d at %0d nonseq=%0d stall_hi=%0d, want 1 at 1, 0, 0",
                     o_err_cnt, o_err_at, o_nonseq, o_stall_hi);
        end
        compared++;
        if (dmdata !== exp_dm) begin
            mismatched++;
            $display("FAIL illegal_dm_hold: got %h want %h", dmdata, exp_dm);
        end
    endtask

    task automatic test_bus_error();
        do_txn(1'b1, 1'b0, 32'h0000_5008, 32'hBEEF_0000, 4'b1100, 0, 0, 1'b1, 32'h0);
        compared++;
        if (o_haddr !== 32'h0000_500A || o_hsize !== 3'b001) begin
            mismatched++;
            $display("FAIL bus_err_addr: haddr=%h hsize=%b, want 0000500a/001", o_haddr, o_hsize);
        end
        compared++;
        if (o_cycles !== 4 || o_err_cnt !== 1 || o_err_at !== 4 || o_rdv_cnt !== 0) begin
            mismatched++;
            $display("FAIL bus_err_resp: cycles=%0d err=%0d at %0d rdv=%0d, want 4, 1 at 4, 0",
                     o_cycles, o_err_cnt, o_err_at, o_rdv_cnt);
        end
        do_txn(1'b1, 1'b0, 32'h0000_500C, 32'hCAFE_F00D, 4'b1111, 0, 0, 1'b0, 32'h0);
        compared++;
        if (o_cycles !== 3 || o_err_cnt !== 0 || o_hwdata !== 32'hCAFE_F00D) begin
            mismatched++;
            $display("FAIL bus_err_next: cycles=%0d err=%0d hwdata=%h, want 3/0/cafef00d",
                     o_cycles, o_err_cnt, o_hwdata);
        end
    endtask

    task automatic test_timeout();
        do_txn(1'b0, 1'b1, 32'h0000_6000, 32'h0, 4'b0000, 0, 100, 1'b0, 32'h1111_2222);
        compared++;
        if (o_cycles !== 2 + TMO || o_err_cnt !== 1 || o_rdv_cnt !== 0 || o_hung !== 1'b0) begin
            mismatched++;
            $display("FAIL timeout_data: cycles=%0d err=%0d rdv=%0d hung=%0b, want %0d/1/0/0",
                     o_cycles, o_err_cnt, o_rdv_cnt, o_hung, 2 + TMO);
        end
        do_txn(1'b1, 1'b0, 32'h0000_6004, 32'h0000_00FF, 4'b0001, 100, 0, 1'b0, 32'h0);
        compared++;
        if (o_cycles !== 1 + TMO || o_nonseq !== TMO || o_err_cnt !== 1) begin
            mismatched++;
            $display("FAIL timeout_addr: cycles=%0d nonseq=%0d err=%0d, want %0d/%0d/1",
                     o_cycles, o_nonseq, o_err_cnt, 1 + TMO, TMO);
        end
        @(negedge clk);
        compared++;
        if (htrans !== 2'b00 || stall !== 1'b0 || dmdata !== exp_dm) begin
            mismatched++;
            $display("FAIL timeout_idle: htrans=%b stall=%b dm=%h, want 00/0/%h",
                     htrans, stall, dmdata, exp_dm);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd_val;
        rd_req = 1'b1;
        addr = 32'h0000_3008;
        hrdata = 32'h5555_AAAA;
        hready = 1'b1;
        hresp = 1'b0;
        tick();
        tick();
        hready = 1'b0;
        tick();
        rst = 1'b1;
        rd_req = 1'b0;
        tick();
        @(negedge clk);
        compared++;
        if ({htrans, haddr, hsize, hwrite, hwdata, dmdata, rdv, err, stall} !== '0) begin
            mismatched++;
            $display("FAIL reset_mid: htrans=%b haddr=%h hsize=%b hwrite=%b hwdata=%h dm=%h rdv=%b err=%b stall=%b, want all 0",
                     htrans, haddr, hsize, hwrite, hwdata, dmdata, rdv, err, stall);
        end
        tick();
        rst = 1'b0;
        hready = 1'b1;
        exp_dm = '0;
        @(negedge clk);
        compared++;
        if (rdv !== 1'b0 || err !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_mid_pulse: rdv=%b err=%b, want 0/0", rdv, err);
        end
        tick();
        rd_val = $urandom;
        do_txn(1'b0, 1'b1, 32'h0000_3008, 32'h0, 4'b0000, 0, 0, 1'b0, rd_val);
        exp_dm = rd_val;
        compared++;
        if (o_cycles !== 3 || o_rdv_cnt !== 1 || dmdata !== exp_dm) begin
            mismatched++;
            $display("FAIL reset_mid_recover: cycles=%0d rdv=%0d dm=%h, want 3/1/%h",
                     o_cycles, o_rdv_cnt, dmdata, exp_dm);
        end
    endtask

    task automatic test_random();
        logic [3:0] legal_masks [7];
        legal_masks = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
        for (int i = 0; i < 60; i++) begin
            bit w;
            bit r;
            int kind;
            int aw;
            int dw;
            bit berr;
            logic [31:0] a;
            logic [31:0] d;
            logic [31:0] rv;
            logic [3:0] m;
            exp_t e;
            kind = $urandom_range(0, 9);
            w = (kind <= 4);
            r = (kind == 0) || (kind >= 5);
            a = $urandom;
            d = $urandom;
            rv = $urandom;
            if ($urandom_range(0, 1) == 0) m = legal_masks[$urandom_range(0, 6)];
            else m = 4'($urandom_range(0, 15));
            aw = $urandom_range(0, 2);
            dw = $urandom_range(0, 3);
            berr = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 19) == 0) dw = TMO + 4;
            else if ($urandom_range(0, 19) == 0) aw = TMO + 4;
            e = model(w, r, a, m, aw, dw, berr);
            do_txn(w, r, a, d, m, aw, dw, berr, rv);
            if (e.rdv) exp_dm = rv;
            compared++;
            if (o_cycles !== e.cycles || o_stall_hi !== (e.bus ? e.cycles - 1 : 0) || o_hung) begin
                mismatched++;
                $display("FAIL rnd%0d timing: cycles=%0d stall_hi=%0d hung=%0b, want %0d/%0d/0",
                         i, o_cycles, o_stall_hi, o_hung, e.cycles, e.bus ? e.cycles - 1 : 0);
            end
            compared++;
            if (o_nonseq !== e.nonseq) begin
                mismatched++;
                $display("FAIL rnd%0d nonseq: got %0d want %0d", i, o_nonseq, e.nonseq);
            end
            compared++;
            if (o_err_cnt !== int'(e.err) || o_rdv_cnt !== int'(e.rdv)) begin
                mismatched++;
                $display("FAIL rnd%0d pulses: err=%0d rdv=%0d, want %0d/%0d",
                         i, o_err_cnt, o_rdv_cnt, e.err, e.rdv);
            end
            if (e.bus) begin
                compared++;
                if (o_haddr !== e.haddr || o_hsize !== e.hsize || o_hwrite !== w) begin
                    mismatched++;
                    $display("FAIL rnd%0d addr: haddr=%h hsize=%b hwrite=%b, want %h/%b/%b",
                             i, o_haddr, o_hsize, o_hwrite, e.haddr, e.hsize, w);
                end
            end
            if (e.bus && w && e.dphase) begin
                compared++;
                if (o_hwdata !== d) begin
                    mismatched++;
                    $display("FAIL rnd%0d hwdata: got %h want %h", i, o_hwdata, d);
                end
            end
            compared++;
            if (dmdata !== exp_dm) begin
                mismatched++;
                $display("FAIL rnd%0d dmdata: got %h want %h", i, dmdata, exp_dm);
            end
        end
    endtask

    initial begin
        test_reset();
        test_store_byte();
        test_load_wait();
        test_illegal();
        test_bus_error();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
